// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master fed by a command/response handshake.
// Every output is a flop; the next value of each is decided in the FSM comb block.
module axil_cmd_master (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        rsp_write,
  output logic [15:0] err_count,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RSP
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] err_count_q, err_count_d;
  logic        aw_ok, w_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A channel counts as finished once its VALID has already dropped or is handshaking now.
  assign aw_ok = !awvalid_q || M_AXI_AWREADY;
  assign w_ok  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_data_d  = rsp_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_count_d = err_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = {cmd_addr[31:2], 2'b00};
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_resp_d  = M_AXI_BRESP;
          if (M_AXI_BRESP != 2'b00) err_count_d = sat_inc(err_count_q);
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_data_d  = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          if (M_AXI_RRESP != 2'b00) err_count_d = sat_inc(err_count_q);
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_data_q  <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_data_q  <= rsp_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_write     = rsp_write_q;
  assign err_count     = err_count_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: configurable AXI4-Lite slave model, bus monitors
// and a queue of expected responses popped as the DUT answers.
module tb_axil_cmd_master;
  logic        clk, resetn, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic w; logic [31:0] d; logic [1:0] r;} exp_t;
  exp_t sb[$];

  axil_cmd_master dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_count(err_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_AWPROT(awprot), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARPROT(arprot),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: READY after a programmable wait, response one cycle after it is due.
  int aw_wait = 0, w_wait = 0, ar_wait = 0;
  int aw_cnt, w_cnt, ar_cnt;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'd0;
  logic aw_seen, w_seen, b_pend, r_pend;
  wire aw_hs = awvalid && awready;
  wire w_hs  = wvalid && wready;
  wire ar_hs = arvalid && arready;
  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid && (ar_cnt >= ar_wait);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= 32'd0; rresp <= 2'b00;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
        aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b1;
      end else begin
        if (aw_hs) aw_seen <= 1'b1;
        if (w_hs)  w_seen <= 1'b1;
      end
      if (b_pend) begin
        bvalid <= 1'b1; bresp <= b_resp_cfg; b_pend <= 1'b0;
      end else if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) r_pend <= 1'b1;
      if (r_pend) begin
        rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; r_pend <= 1'b0;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Bus monitors
  int aw_hi = 0, w_hi = 0, bready_early = 0, rsp_hs = 0, hold_viol = 0, prot_viol = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(posedge clk) begin
    aw_hi <= aw_hi + (awvalid ? 1 : 0);
    w_hi  <= w_hi + (wvalid ? 1 : 0);
    if (bready && (awvalid || wvalid)) bready_early <= bready_early + 1;
    if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
    if ((awvalid && (awprot != 3'd0 || wstrb != 4'hF)) || (arvalid && arprot != 3'd0))
      prot_viol <= prot_viol + 1;
    if (aw_hs) last_awaddr <= awaddr;
    if (w_hs) begin last_wdata <= wdata; last_wstrb <= wstrb; end
    if (ar_hs) last_araddr <= araddr;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= 32'd0; p_wdata <= 32'd0; p_araddr <= 32'd0;
    end else begin
      if ((p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) ||
          (p_wv && !p_wr && (!wvalid || wdata !== p_wdata)) ||
          (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)))
        hold_viol <= hold_viol + 1;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  time t_acc;

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit keep_valid, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    ok = cmd_ready;
    @(posedge clk);
    t_acc = $time;
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pop_exp(output exp_t e, output bit got);
    got = (sb.size() != 0);
    e = '0;
    if (got) e = sb.pop_front();
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_write, err_count, awaddr, awvalid,
         wdata, wvalid, bready, araddr, arvalid, rready} !== '0) begin
      failures++; $display("FAIL reset_outputs cmd_ready=%b rsp_valid=%b awvalid=%b arvalid=%b err=%h required all zero",
                           cmd_ready, rsp_valid, awvalid, arvalid, err_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge actual=%b required=0", cmd_ready); end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge actual=%b required=1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    bit ok, got; int lat; exp_t e;
    sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
    send_cmd(1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 1'b0, ok);
    wait_rsp(ok, lat);
    checks++;
    if (!ok || lat != 4) begin failures++; $display("FAIL wr_latency actual=%0d required=4 (seen=%b)", lat, ok); end
    pop_exp(e, got);
    checks++;
    if (!got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL wr_rsp actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
    checks++;
    if ({last_awaddr, last_wdata, last_wstrb} !== {32'h10, 32'hDEAD_BEEF, 4'hF}) begin
      failures++; $display("FAIL wr_bus actual=%h/%h/%h required=00000010/deadbeef/f", last_awaddr, last_wdata, last_wstrb);
    end
    checks++;
    if (err_count !== 16'd0) begin failures++; $display("FAIL wr_err_count actual=%h required=0000", err_count); end
  endtask

  task automatic test_read_basic;
    bit ok, got; int lat; exp_t e;
    r_data_cfg = 32'h0000_0005;
    sb.push_back('{w: 1'b0, d: 32'h5, r: 2'b00});
    send_cmd(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 1'b0, ok);
    wait_rsp(ok, lat);
    checks++;
    if (!ok || lat != 4) begin failures++; $display("FAIL rd_latency actual=%0d required=4 (seen=%b)", lat, ok); end
    pop_exp(e, got);
    checks++;
    if (!got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL rd_rsp actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
    checks++;
    if (last_araddr !== 32'h8) begin failures++; $display("FAIL rd_araddr actual=%h required=00000008", last_araddr); end
  endtask

  task automatic test_back_to_back;
    bit ok, got; int lat; exp_t e; time t1;
    r_data_cfg = 32'h0000_00A1;
    sb.push_back('{w: 1'b0, d: 32'hA1, r: 2'b00});
    send_cmd(1'b0, 32'h0000_0100, 32'd0, 1'b0, ok);
    t1 = t_acc;
    wait_rsp(ok, lat);
    pop_exp(e, got);
    checks++;
    if (!ok || !got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL b2b_rsp1 actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
    sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
    send_cmd(1'b1, 32'h0000_0104, 32'h0BAD_F00D, 1'b0, ok);
    checks++;
    if (!ok || (t_acc - t1) != 50) begin failures++; $display("FAIL b2b_spacing actual=%0t required=50", t_acc - t1); end
    wait_rsp(ok, lat);
    pop_exp(e, got);
    checks++;
    if (!ok || !got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL b2b_rsp2 actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
  endtask

  task automatic test_aw_delay;
    bit ok, got; int lat; exp_t e; int aw0, w0, be0, hs0;
    aw_wait = 3;
    @(negedge clk);
    aw0 = aw_hi; w0 = w_hi; be0 = bready_early; hs0 = rsp_hs;
    sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
    send_cmd(1'b1, 32'h0000_0204, 32'h1111_2222, 1'b0, ok);
    wait_rsp(ok, lat);
    pop_exp(e, got);
    checks++;
    if (!ok || !got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL awdly_rsp actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
    checks++;
    if (aw_hi - aw0 != 4 || w_hi - w0 != 1) begin
      failures++; $display("FAIL awdly_valid_cycles actual aw=%0d w=%0d required aw=4 w=1", aw_hi - aw0, w_hi - w0);
    end
    checks++;
    if (bready_early != be0) begin failures++; $display("FAIL awdly_bready_early actual=%0d required=%0d", bready_early, be0); end
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_hs - hs0 != 1) begin failures++; $display("FAIL awdly_rsp_count actual=%0d required=1", rsp_hs - hs0); end
    aw_wait = 0;
  endtask

  task automatic test_err_count;
    bit ok, got; int lat; exp_t e;
    r_resp_cfg = 2'b11;
    for (int i = 0; i < 3; i++) begin
      r_data_cfg = 32'hBAD0_0000 + i;
      sb.push_back('{w: 1'b0, d: 32'hBAD0_0000 + i, r: 2'b11});
      send_cmd(1'b0, 32'h0000_0300 + 4 * i, 32'd0, 1'b0, ok);
      wait_rsp(ok, lat);
      pop_exp(e, got);
      checks++;
      if (!ok || !got || {rsp_write, rsp_data, rsp_resp} !== e) begin
        failures++; $display("FAIL decerr_rsp%0d actual=%b/%h/%h required=%b/%h/%h", i, rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
      end
    end
    @(negedge clk);
    checks++;
    if (err_count !== 16'd3) begin failures++; $display("FAIL err_count3 actual=%h required=0003", err_count); end
    r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b10;
    sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b10});
    send_cmd(1'b1, 32'h0000_0310, 32'h5, 1'b0, ok);
    wait_rsp(ok, lat);
    pop_exp(e, got);
    checks++;
    if (!ok || !got || {rsp_write, rsp_data, rsp_resp, err_count} !== {e, 16'd4}) begin
      failures++; $display("FAIL slverr_wr actual=%b/%h/%h err=%h required=%b/%h/%h err=0004",
                           rsp_write, rsp_data, rsp_resp, err_count, e.w, e.d, e.r);
    end
    b_resp_cfg = 2'b00;
    @(negedge clk);
    force dut.err_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_count_q;
    @(negedge clk);
    checks++;
    if (err_count !== 16'hFFFF) begin failures++; $display("FAIL err_preload actual=%h required=ffff", err_count); end
    r_resp_cfg = 2'b11; r_data_cfg = 32'h0;
    sb.push_back('{w: 1'b0, d: 32'h0, r: 2'b11});
    send_cmd(1'b0, 32'h0000_0320, 32'd0, 1'b0, ok);
    wait_rsp(ok, lat);
    pop_exp(e, got);
    @(negedge clk);
    checks++;
    if (!ok || !got || err_count !== 16'hFFFF) begin failures++; $display("FAIL err_saturate actual=%h required=ffff", err_count); end
    r_resp_cfg = 2'b00;
  endtask

  task automatic test_backpressure;
    bit ok, got; int lat, viol; exp_t e;
    logic [35:0] snap;
    rsp_ready = 1'b0;
    r_data_cfg = 32'hCAFE_0020;
    sb.push_back('{w: 1'b0, d: 32'hCAFE_0020, r: 2'b00});
    send_cmd(1'b0, 32'h0000_0020, 32'd0, 1'b1, ok);
    cmd_write = 1'b1; cmd_addr = 32'h0000_0044; cmd_wdata = 32'h1234_5678;
    wait_rsp(ok, lat);
    snap = {rsp_valid, rsp_write, rsp_data, rsp_resp};
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready || {rsp_valid, rsp_write, rsp_data, rsp_resp} !== snap) viol++;
    end
    checks++;
    if (!ok || viol != 0) begin failures++; $display("FAIL bp_stable actual_violations=%0d required=0", viol); end
    pop_exp(e, got);
    checks++;
    if (!got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL bp_rsp actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
    sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
      failures++; $display("FAIL bp_idle_after_hs actual cmd_ready=%b awvalid=%b required 1/0", cmd_ready, awvalid);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h44) begin
      failures++; $display("FAIL bp_next_accept actual awvalid=%b awaddr=%h required 1/00000044", awvalid, awaddr);
    end
    wait_rsp(ok, lat);
    pop_exp(e, got);
    checks++;
    if (!ok || !got || {rsp_write, rsp_data, rsp_resp} !== e) begin
      failures++; $display("FAIL bp_rsp2 actual=%b/%h/%h required=%b/%h/%h", rsp_write, rsp_data, rsp_resp, e.w, e.d, e.r);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; int hs0;
    ar_wait = 1000;
    send_cmd(1'b0, 32'h0000_0030, 32'd0, 1'b0, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || arvalid !== 1'b1) begin failures++; $display("FAIL rstmid_arvalid actual=%b required=1", arvalid); end
    #2; resetn = 1'b0; #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_write, err_count, awaddr, awvalid,
         wdata, wvalid, bready, araddr, arvalid, rready} !== '0) begin
      failures++; $display("FAIL rstmid_outputs cmd_ready=%b arvalid=%b rready=%b err=%h araddr=%h required all zero",
                           cmd_ready, arvalid, rready, err_count, araddr);
    end
    ar_wait = 0;
    hs0 = rsp_hs;
    @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready actual=%b required=1", cmd_ready); end
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_hs != hs0 || rsp_valid !== 1'b0 || arvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_stale actual hs=%0d rsp_valid=%b arvalid=%b required hs=%0d 0 0", rsp_hs, rsp_valid, arvalid, hs0);
    end
    checks++;
    if (hold_viol != 0 || prot_viol != 0 || sb.size() != 0) begin
      failures++; $display("FAIL bus_rules actual hold=%0d prot=%0d leftover=%0d required 0/0/0", hold_viol, prot_viol, sb.size());
    end
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'd0; cmd_wdata = 32'd0; rsp_ready = 1'b1;
    test_reset();
    test_write_zero_wait();
    test_read_basic();
    test_back_to_back();
    test_aw_delay();
    test_err_count();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
